capture_tx_ctrl: RTL and testbench



---
 rtl/capture_tx_ctrl.sv | 134 +++++++++++++
 tb/tb_capture_tx_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/capture_tx_ctrl.sv
// capture_tx_ctrl: one capture run = load pt/key, fire the cipher, wait a fixed
// window, then stream a frame (header, pt, key, ct, trace bytes) byte by byte
// to a UART, then idle for a settle gap before accepting the next start.
module capture_tx_ctrl #(
  parameter int         SAMPLES     = 1024,
  parameter int         WAIT_CYCLES = 1024,
  parameter int         GAP_CYCLES  = 4096,
  parameter logic [7:0] HEADER      = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pt_in,
  input  logic [63:0] key_in,
  output logic        enc_en,
  input  logic        enc_done,
  input  logic [31:0] ct_in,
  output logic [9:0]  trace_addr,
  input  logic [7:0]  trace_data,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  input  logic        tx_done,
  output logic        busy,
  output logic        timeout_err
);

  localparam int FRAME   = 17 + SAMPLES;
  localparam int IDX_W   = ($clog2(FRAME) > 11) ? $clog2(FRAME) : 11;
  localparam int CNT_MAX = (WAIT_CYCLES > GAP_CYCLES) ? WAIT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ENC, WAIT_ENC, FETCH, SEND, WAIT_TX, GAP
  } state_t;

  state_t            state, state_nx;
  logic [31:0]       pt_r, ct_r;
  logic [63:0]       key_r;
  logic              done_f;
  logic [CNT_W-1:0]  cnt;        // shared: capture window, then settle gap
  logic [IDX_W-1:0]  idx;        // byte index within the frame
  logic              win_end, gap_end, last_byte, ct_hit;
  logic [16:0][7:0]  hdr;        // fixed 17-byte frame prefix, header in MSB
  logic [7:0]        sel;

  assign win_end   = (cnt == CNT_W'(WAIT_CYCLES - 1));
  assign gap_end   = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign last_byte = (idx == IDX_W'(FRAME - 1));
  // only the first enc_done of the window is taken; later ones are ignored
  assign ct_hit    = enc_done && !done_f && ((state == ENC) || (state == WAIT_ENC));

  assign enc_en = (state == ENC);
  assign tx_dv  = (state == SEND);
  assign busy   = (state != IDLE);
  // prefix bytes park the trace address at 0; trace bytes map to idx-17
  assign trace_addr = (idx >= IDX_W'(17)) ? 10'(idx - IDX_W'(17)) : 10'd0;
  assign hdr = {HEADER, pt_r, key_r, ct_r};

  // state register; reset drops straight back to IDLE from anywhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (start) state_nx = LOAD;
      LOAD:     state_nx = ENC;
      ENC:      state_nx = WAIT_ENC;
      WAIT_ENC: if (win_end) state_nx = FETCH;
      FETCH:    state_nx = SEND;
      SEND:     state_nx = WAIT_TX;
      WAIT_TX:  if (tx_done) state_nx = last_byte ? GAP : FETCH;
      GAP:      if (gap_end) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // run datapath: operand latch, ct capture, window/gap counter, byte index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pt_r        <= '0;
      key_r       <= '0;
      ct_r        <= '0;
      done_f      <= 1'b0;
      cnt         <= '0;
      idx         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) timeout_err <= 1'b0;
        LOAD: begin
          pt_r   <= pt_in;
          key_r  <= key_in;
          ct_r   <= '0;
          done_f <= 1'b0;
        end
        ENC: cnt <= '0;
        WAIT_ENC: begin
          if (win_end) begin
            idx <= '0;
            // nothing came back in the window: send all-ones ct and flag it
            if (!done_f && !enc_done) begin
              ct_r        <= 32'hFFFF_FFFF;
              timeout_err <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_TX: if (tx_done) begin
          if (last_byte) cnt <= '0;
          else           idx <= idx + 1'b1;
        end
        GAP: if (!gap_end) cnt <= cnt + 1'b1;
        default: ;
      endcase
      if (ct_hit) begin
        ct_r   <= ct_in;
        done_f <= 1'b1;
      end
    end
  end

  // byte mux: fixed prefix from registers, then the trace stream
  always_comb begin
    sel = trace_data;
    if (idx < IDX_W'(17)) sel = hdr[5'd16 - idx[4:0]];
    tx_byte = tx_dv ? sel : 8'h00;
  end

endmodule

// File: tb/tb_capture_tx_ctrl.sv
// tb_capture_tx_ctrl: randomized runs against a frame-level reference model.
module tb_capture_tx_ctrl;
  localparam int SAMPLES = 1024;
  localparam int WAITC   = 64;
  localparam int GAPC    = 32;
  localparam int FRAME   = 17 + SAMPLES;

  logic        clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [31:0] pt_in = '0, ct_in = '0;
  logic [63:0] key_in = '0;
  logic        enc_done = 1'b0, tx_done = 1'b0;
  logic [7:0]  trace_data = '0;
  logic        enc_en, tx_dv, busy, timeout_err;
  logic [9:0]  trace_addr;
  logic [7:0]  tx_byte;

  int          nchk = 0, nerr = 0;
  int          cyc = 0, last_cyc = -1, enc_cnt = 0;
  int          dly = 0, stray_en = 0, enc_on = 0, enc_at = 0, enc_len = 0;
  logic [31:0] ct_base = '0;
  logic [7:0]  tseed = '0;
  logic [7:0]  rxq[$];

  capture_tx_ctrl #(.SAMPLES(SAMPLES), .WAIT_CYCLES(WAITC), .GAP_CYCLES(GAPC), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst), .start(start), .pt_in(pt_in), .key_in(key_in),
    .enc_en(enc_en), .enc_done(enc_done), .ct_in(ct_in),
    .trace_addr(trace_addr), .trace_data(trace_data),
    .tx_dv(tx_dv), .tx_byte(tx_byte), .tx_done(tx_done),
    .busy(busy), .timeout_err(timeout_err));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // trace memory: one-cycle read latency, content addr ^ seed
  always @(posedge clk) trace_data <= trace_addr[7:0] ^ tseed;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor: collect strobes, check byte period, count cipher starts
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      if (last_cyc >= 0) chk("period", 64'(cyc - last_cyc), 64'(3 + dly));
      last_cyc = cyc;
      rxq.push_back(tx_byte);
    end
    if (enc_en) enc_cnt++;
  end

  // UART responder: tx_done dly+1 cycles after strobe; stray mode also
  // raises tx_done in SEND and in the following FETCH
  initial begin
    int rcnt;
    rcnt = -1;
    forever begin
      @(negedge clk);
      if (tx_dv) begin
        rcnt = 0;
        tx_done = (stray_en != 0);
      end else if (rcnt >= 0) begin
        rcnt++;
        if (rcnt == dly + 1) tx_done = 1'b1;
        else if (rcnt == dly + 2 && stray_en != 0) tx_done = 1'b1;
        else begin
          tx_done = 1'b0;
          if (rcnt > dly + 2) rcnt = -1;
        end
      end else tx_done = 1'b0;
    end
  end

  // cipher model: after enc_en, wait enc_at cycles, then done for enc_len
  // cycles with ct_in stepping each cycle
  initial begin
    ct_in = $urandom;
    forever begin
      @(negedge clk);
      if (enc_en && enc_on != 0) begin
        for (int i = 0; i < enc_at; i++) begin ct_in = $urandom; @(negedge clk); end
        for (int i = 0; i < enc_len; i++) begin
          enc_done = 1'b1;
          ct_in = ct_base + 32'(i);
          @(negedge clk);
        end
        enc_done = 1'b0;
        ct_in = $urandom;
      end
    end
  end

  task automatic run(input logic [31:0] pt, input logic [63:0] key, input int en,
                     input int at, input int len, input int d, input int st, input int rst_at);
    logic [7:0]  exp_q[$];
    logic [31:0] cte;
    int          n, t;
    cte = (en != 0) ? ct_base : 32'hFFFF_FFFF;
    exp_q = {};
    exp_q.push_back(8'hA5);
    for (int i = 3; i >= 0; i--) exp_q.push_back(pt[8*i +: 8]);
    for (int i = 7; i >= 0; i--) exp_q.push_back(key[8*i +: 8]);
    for (int i = 3; i >= 0; i--) exp_q.push_back(cte[8*i +: 8]);
    for (int i = 0; i < SAMPLES; i++) exp_q.push_back(8'(i) ^ tseed);
    n = (rst_at > 0) ? rst_at + 1 : FRAME;

    @(negedge clk);
    pt_in = pt; key_in = key; enc_on = en; enc_at = at; enc_len = len;
    dly = d; stray_en = st; rxq = {}; enc_cnt = 0; last_cyc = -1;
    start = 1'b1;
    @(negedge clk); #1;
    if (st == 0) start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("terr_clr", timeout_err, 0);
    @(negedge clk); #1;
    pt_in = $urandom; key_in = {$urandom, $urandom};   // operands already latched

    t = 0;
    while (rxq.size() < n && t < 40000) begin @(negedge clk); #1; t++; end
    chk("frame_len", 64'(rxq.size()), 64'(n));
    start = 1'b0;

    if (rst_at > 0) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_dv", tx_dv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_byte", tx_byte, 0);
      chk("rst_addr", trace_addr, 0);
      chk("rst_terr", timeout_err, 0);
    end else begin
      @(negedge clk); #1;
      chk("terr_frame", timeout_err, (en == 0));
      t = 0;
      while (busy && t < 1000) begin @(negedge clk); #1; t++; end
      chk("busy_fall", busy, 0);
      chk("terr_idle", timeout_err, (en == 0));
      chk("last_addr", trace_addr, SAMPLES - 1);
      repeat (10) @(negedge clk);
      #1;
      chk("no_requeue", busy, 0);
      chk("frame_len_end", 64'(rxq.size()), 64'(n));
    end
    chk("enc_pulses", 64'(enc_cnt), 1);
    for (int i = 0; i < n && i < rxq.size(); i++)
      chk($sformatf("byte%0d", i), rxq[i], exp_q[i]);
    if (rst_at > 0) begin
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst0_enc_en", enc_en, 0);
    chk("rst0_dv", tx_dv, 0);
    chk("rst0_byte", tx_byte, 0);
    chk("rst0_addr", trace_addr, 0);
    chk("rst0_busy", busy, 0);
    chk("rst0_terr", timeout_err, 0);
    rst = 1'b0;

    // reference frame, trace = addr, tx_done 5 cycles after each strobe
    tseed = 8'h00; ct_base = 32'hC69BE9BB;
    run(32'h65656877, 64'h1918111009080100, 1, 38, 1, 4, 0, 0);
    // cipher never answers
    tseed = 8'($urandom);
    run($urandom, {$urandom, $urandom}, 0, 0, 0, $urandom_range(0, 2), 0, 0);
    // start held high, stray tx_done, long enc_done with moving ct
    tseed = 8'($urandom); ct_base = $urandom;
    run($urandom, {$urandom, $urandom}, 1, $urandom_range(0, 40), 10, $urandom_range(1, 3), 1, 0);
    // reset mid-frame in WAIT_TX of byte 500
    tseed = 8'($urandom); ct_base = $urandom;
    run($urandom, {$urandom, $urandom}, 1, $urandom_range(0, 50), $urandom_range(1, 3), 3, 0, 500);
    // fresh frame after reset at minimum byte period
    tseed = 8'($urandom); ct_base = $urandom;
    run($urandom, {$urandom, $urandom}, 1, $urandom_range(0, 60), 1, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
